// File: rtl/sram_sp_req_ctrl.sv
// Single-port SRAM request front-end: round-robin write/read arbitration and a credit-managed response FIFO.
// Define SRAM_INIT_EN to walk INIT_VALUE through every address after reset before accepting requests.
module sram_sp_req_ctrl #(
    parameter int unsigned        DATA_W     = 80,
    parameter int unsigned        ADDR_W     = 8,
    parameter int unsigned        WORDS      = 256,
    parameter int unsigned        RESP_DEPTH = 4,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RESP_DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef enum logic {RR_WRITE, RR_READ} rr_t;

    state_t            state;
    rr_t               rr_ptr;
    logic [ADDR_W-1:0] init_addr;
    logic              init_active;
    logic              run;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  credits;
    logic              has_credit;
    logic              rd_inflight;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];

    logic              w_fire;
    logic              r_fire;
    logic              contested;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] a_hold;
    logic [DATA_W-1:0] d_hold;

`ifdef SRAM_INIT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else if (state == ST_INIT) begin
            init_addr <= init_addr + 1'b1;
            if (init_addr == ADDR_W'(WORDS - 1))
                state <= ST_RUN;
        end
    end

    assign init_active = reset_n && (state == ST_INIT);
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= ST_RUN;
    end

    assign init_addr   = '0;
    assign init_active = 1'b0;
`endif

    // Gating with reset_n keeps the macro deselected while reset is held.
    assign run       = reset_n && (state == ST_RUN);
    assign init_done = (state == ST_RUN);

    // Credits come from registered state only; a pop this cycle frees a slot next cycle.
    assign credits    = CNT_W'(RESP_DEPTH) - count - CNT_W'(rd_inflight);
    assign has_credit = (credits != '0);

    always_comb begin
        r_ready = run && has_credit && (!w_valid || rr_ptr == RR_READ);
        w_ready = run && (!r_valid || !has_credit || rr_ptr == RR_WRITE);
    end

    assign w_fire    = w_valid && w_ready;
    assign r_fire    = r_valid && r_ready;
    assign contested = w_valid && r_valid && has_credit;

    always_comb begin
        sram_ceb = !(w_fire || r_fire || init_active);
        sram_web = !(w_fire || init_active);
        if (w_fire)
            sram_a = w_addr;
        else if (r_fire)
            sram_a = r_addr;
        else if (init_active)
            sram_a = init_addr;
        else
            sram_a = a_hold;
        if (w_fire)
            sram_d = w_data;
        else if (init_active)
            sram_d = INIT_VALUE;
        else
            sram_d = d_hold;
    end

    // Holding the last driven A/D on idle cycles avoids needless pin toggling.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_hold <= '0;
            d_hold <= '0;
            rr_ptr <= RR_WRITE;
        end else begin
            a_hold <= sram_a;
            d_hold <= sram_d;
            if (run && contested)
                rr_ptr <= (rr_ptr == RR_WRITE) ? RR_READ : RR_WRITE;
        end
    end

    assign push       = rd_inflight;
    assign resp_valid = (count != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_inflight <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            rd_inflight <= r_fire;
            count       <= count + CNT_W'(push) - CNT_W'(pop);
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= sram_q;
    end

    fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && count == CNT_W'(RESP_DEPTH)));

endmodule

// File: tb/tb_sram_sp_req_ctrl.sv
// Scoreboard bench for sram_sp_req_ctrl with a behavioural single-port SRAM and a reference memory.
module tb_sram_sp_req_ctrl;

    localparam int DATA_W     = 80;
    localparam int ADDR_W     = 8;
    localparam int WORDS      = 256;
    localparam int RESP_DEPTH = 4;
`ifdef SRAM_INIT_EN
    localparam int INIT_LEN = WORDS;
`else
    localparam int INIT_LEN = 0;
`endif

    logic              clock;
    logic              reset_n;
    logic              w_valid, w_ready, r_valid, r_ready;
    logic [ADDR_W-1:0] w_addr, r_addr, sram_a;
    logic [DATA_W-1:0] w_data, resp_data, sram_d, sram_q;
    logic              resp_valid, resp_ready, init_done, sram_ceb, sram_web;

    sram_sp_req_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .WORDS     (WORDS),
        .RESP_DEPTH(RESP_DEPTH),
        .INIT_VALUE({DATA_W{1'b0}})
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_addr    (r_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .init_done (init_done),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    // Behavioural macro: registers CEB/WEB/A/D on the edge, Q is noise unless the previous cycle read.
    logic [DATA_W-1:0] macro_mem [WORDS];
    initial begin
        for (int i = 0; i < WORDS; i++)
            macro_mem[i] = (INIT_LEN != 0) ? rnd_word() : '0;
        sram_q = rnd_word();
        forever begin
            @(posedge clock);
            if (!sram_ceb && !sram_web)
                macro_mem[sram_a] <= sram_d;
            if (!sram_ceb && sram_web)
                sram_q <= macro_mem[sram_a];
            else
                sram_q <= rnd_word();
        end
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } resp_t;

    logic [DATA_W-1:0] ref_mem [WORDS];
    resp_t             exp_q[$];
    resp_t             head;
    int                cyc = 0;
    int                rel_cyc = 0;
    int                outstanding = 0;
    bit                rr_w = 1'b1;
    logic [ADDR_W-1:0] last_a = '0;
    logic [DATA_W-1:0] last_d = '0;
    bit                m_init, m_run, m_cand_r, m_contested, m_wf, m_rf, m_rv;
    logic [ADDR_W-1:0] m_a;
    logic [DATA_W-1:0] m_d;

    // Monitor: predicts grants, pin activity and response timing from accepted traffic.
    initial begin
        for (int i = 0; i < WORDS; i++)
            ref_mem[i] = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                chk("rst_ceb", sram_ceb, 1);
                chk("rst_web", sram_web, 1);
                chk("rst_resp_valid", resp_valid, 0);
                exp_q.delete();
                outstanding = 0;
                rr_w        = 1'b1;
                last_a      = '0;
                last_d      = '0;
                rel_cyc     = 0;
            end else begin
                m_init      = (rel_cyc < INIT_LEN);
                m_run       = !m_init;
                m_cand_r    = r_valid && (outstanding < RESP_DEPTH);
                m_contested = w_valid && m_cand_r;
                m_wf        = m_run && w_valid && (!m_contested || rr_w);
                m_rf        = m_run && m_cand_r && (!m_contested || !rr_w);
                m_a = m_wf ? w_addr : m_rf ? r_addr : m_init ? ADDR_W'(rel_cyc) : last_a;
                m_d = m_wf ? w_data : m_init ? '0 : last_d;
                chk("init_done", init_done, m_run);
                chk("w_grant", w_valid && w_ready, m_wf);
                chk("r_grant", r_valid && r_ready, m_rf);
                chk("sram_ceb", sram_ceb, !(m_wf || m_rf || m_init));
                chk("sram_web", sram_web, !(m_wf || m_init));
                chk("sram_a", sram_a, m_a);
                chk("sram_d", sram_d, m_d);
                if (!sram_ceb)
                    assert (int'(sram_a) < WORDS);
                last_a = m_a;
                last_d = m_d;

                m_rv = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
                chk("resp_valid", resp_valid, m_rv);
                if (resp_valid && resp_ready && exp_q.size() > 0) begin
                    head = exp_q.pop_front();
                    chk("resp_data", resp_data, head.data);
                    outstanding--;
                end
                if (m_wf)
                    ref_mem[w_addr] = w_data;
                if (m_rf) begin
                    exp_q.push_back('{data: ref_mem[r_addr], due: cyc + 2});
                    outstanding++;
                end
                if (m_run && m_contested)
                    rr_w = !rr_w;
                rel_cyc++;
            end
        end
    end

    task automatic issue_w(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit ok = 1'b0;
        w_valid = 1'b1;
        w_addr  = a;
        w_data  = d;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clock);
            ok = w_ready;
        end
        chk("issue_w_accept", ok, 1);
        @(posedge clock);
        #1 w_valid = 1'b0;
    endtask

    task automatic accept_r(input logic [ADDR_W-1:0] a, output int waits);
        bit ok = 1'b0;
        waits   = 0;
        r_valid = 1'b1;
        r_addr  = a;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clock);
            ok = r_ready;
            waits++;
        end
        chk("issue_r_accept", ok, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic issue_r(input logic [ADDR_W-1:0] a);
        int w;
        accept_r(a, w);
        r_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        resp_ready = 1'b1;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clock);
            ok = (exp_q.size() == 0) && (outstanding == 0);
        end
        chk("drain", ok, 1);
        @(posedge clock);
        #1;
    endtask

    int total_waits, w, k, wg, rg;

    initial begin
        reset_n = 1'b0; w_valid = 1'b0; r_valid = 1'b0; resp_ready = 1'b1;
        w_addr = '0; r_addr = '0; w_data = '0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (INIT_LEN + 2) @(posedge clock);
        #1;

        // Reads of unwritten corners, then write followed immediately by a read of the same word.
        issue_r(8'h00);
        issue_r(8'hFF);
        issue_w(8'h12, {10{8'hA5}});
        issue_r(8'h12);
        for (int i = 0; i < 48; i++)
            issue_w(ADDR_W'(i), rnd_word());
        drain();

        // Back-to-back streaming reads must not lose a cycle.
        total_waits = 0;
        for (int i = 0; i < 16; i++) begin
            accept_r(ADDR_W'(i), w);
            total_waits += w;
        end
        r_valid = 1'b0;
        chk("t3_cycles", total_waits, 16);
        drain();

        // Stalled consumer: only RESP_DEPTH reads may be accepted.
        resp_ready = 1'b0;
        k = 0;
        r_valid = 1'b1;
        r_addr  = 8'h20;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (r_ready) k++;
            @(posedge clock);
            #1 r_addr = ADDR_W'(32 + k);
        end
        chk("t4_accepted", k, 4);
        @(negedge clock);
        chk("t4_r_ready_low", r_ready, 0);
        @(posedge clock);
        #1 resp_ready = 1'b1;
        for (int c = 0; c < 40 && k < 6; c++) begin
            @(negedge clock);
            if (r_ready) k++;
            @(posedge clock);
            #1 r_addr = ADDR_W'(32 + k);
            r_valid = (k < 6);
        end
        r_valid = 1'b0;
        chk("t4_total", k, 6);
        drain();

        // Both channels saturated: strict alternation, one access every cycle.
        wg = 0; rg = 0;
        w_valid = 1'b1; r_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            w_addr = ADDR_W'($urandom_range(48, 63));
            r_addr = ADDR_W'($urandom_range(48, 63));
            w_data = rnd_word();
            @(negedge clock);
            if (w_ready) wg++;
            if (r_ready) rg++;
            chk("t5_ceb", sram_ceb, 0);
            chk("t5_single_grant", w_ready && r_ready, 0);
            @(posedge clock);
            #1;
        end
        w_valid = 1'b0; r_valid = 1'b0;
        chk("t5_writes", wg, 4);
        chk("t5_reads", rg, 4);
        drain();

        // Reset with two queued responses and one read in flight.
        resp_ready = 1'b0;
        issue_r(8'h01);
        issue_r(8'h02);
        issue_r(8'h03);
        reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk("t6_no_stale_resp", resp_valid, 0);
        end
        repeat (INIT_LEN + 1) @(posedge clock);
        #1;

        // Randomised traffic with address hazards and a bursty consumer.
        for (int c = 0; c < 1500; c++) begin
            w_valid    = ($urandom_range(0, 99) < 50);
            r_valid    = ($urandom_range(0, 99) < 50);
            resp_ready = ($urandom_range(0, 99) < 70);
            w_addr     = ADDR_W'($urandom_range(0, (c % 4 == 0) ? 255 : 15));
            r_addr     = ADDR_W'($urandom_range(0, (c % 4 == 1) ? 255 : 15));
            w_data     = rnd_word();
            @(posedge clock);
            #1;
        end
        w_valid = 1'b0;
        r_valid = 1'b0;
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
